// File: rtl/ysyx_22050243_ctrl_hazard_sb.sv
// ID-stage hazard/forwarding unit for JALR and conditional branches resolved in ID.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   inst_if_2_id_ff, id_valid   instruction in ID and its valid flag
//   flush                       pipeline flush (clears the stall streak only)
//   rd_*/reg_w_*/mem_r_*        destinations of the ID/EX, EX/MEM, MEM/WB producers
//   ld_issue, ld_issue_rd       LSU accepted a load for this destination
//   ld_resp_valid               oldest outstanding load writes the register file this edge
//   fwd_rs1, fwd_rs2            operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_ctrl                  hold ID (combinational)
//   sb_full, stall_cnt          scoreboard full flag, saturating stall-cycle counter
//   hang_err, sb_ovf_err        sticky watchdog / scoreboard overflow errors
module ysyx_22050243_ctrl_hazard_sb #(
  parameter int unsigned GPR_ADDR_WIDTH  = 5,
  parameter int unsigned IBUS_DATA_WIDTH = 32,
  parameter int unsigned LD_DEPTH        = 4,
  parameter int unsigned PERF_CNT_WIDTH  = 16,
  parameter int unsigned STALL_TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IBUS_DATA_WIDTH-1:0] inst_if_2_id_ff,
  input  logic                      id_valid,
  input  logic                      flush,
  input  logic [GPR_ADDR_WIDTH-1:0] rd_id_2_ex_ff,
  input  logic                      reg_w_id_2_ex_ff,
  input  logic [GPR_ADDR_WIDTH-1:0] rd_ex_2_mem_ff,
  input  logic                      reg_w_ex_2_mem_ff,
  input  logic                      mem_r_ex_2_mem_ff,
  input  logic [GPR_ADDR_WIDTH-1:0] rd_mem_2_wb_ff,
  input  logic                      reg_w_mem_2_wb_ff,
  input  logic                      ld_issue,
  input  logic [GPR_ADDR_WIDTH-1:0] ld_issue_rd,
  input  logic                      ld_resp_valid,
  output logic [1:0]                fwd_rs1,
  output logic [1:0]                fwd_rs2,
  output logic                      stall_ctrl,
  output logic                      sb_full,
  output logic [PERF_CNT_WIDTH-1:0] stall_cnt,
  output logic                      hang_err,
  output logic                      sb_ovf_err
);

  localparam int unsigned PTR_W  = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(LD_DEPTH + 1);
  localparam int unsigned STRK_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  // Scoreboard state
  logic [GPR_ADDR_WIDTH-1:0] sb_rd [LD_DEPTH];
  logic [LD_DEPTH-1:0]       sb_valid;
  logic [PTR_W-1:0]          head_q, tail_q;
  logic [CNT_W-1:0]          count_q, count_next;
  logic [STRK_W-1:0]         streak_q;

  // Decode
  logic [6:0]                opcode;
  logic [GPR_ADDR_WIDTH-1:0] rs1, rs2;
  logic                      cand1, cand2;
  logic                      unused_inst_bits;

  assign opcode = inst_if_2_id_ff[6:0];
  assign rs1    = GPR_ADDR_WIDTH'(inst_if_2_id_ff[19:15]);
  assign rs2    = GPR_ADDR_WIDTH'(inst_if_2_id_ff[24:20]);
  assign cand1  = id_valid && ((opcode == OP_JALR) || (opcode == OP_BRANCH)) && (rs1 != '0);
  assign cand2  = id_valid && (opcode == OP_BRANCH) && (rs2 != '0);
  assign unused_inst_bits = ^{inst_if_2_id_ff[IBUS_DATA_WIDTH-1:25], inst_if_2_id_ff[14:7]};

  // Outstanding-load match per operand; the head being popped still counts this cycle
  logic sb_hit1, sb_hit2;
  always_comb begin
    sb_hit1 = 1'b0;
    sb_hit2 = 1'b0;
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      if (sb_valid[i] && (sb_rd[i] == rs1)) sb_hit1 = 1'b1;
      if (sb_valid[i] && (sb_rd[i] == rs2)) sb_hit2 = 1'b1;
    end
  end

  // Stall: ID/EX writer, EX/MEM load, or scoreboard entry
  logic haz1, haz2;
  assign haz1 = cand1 && (((rs1 == rd_id_2_ex_ff) && reg_w_id_2_ex_ff) ||
                          ((rs1 == rd_ex_2_mem_ff) && reg_w_ex_2_mem_ff && mem_r_ex_2_mem_ff) ||
                          sb_hit1);
  assign haz2 = cand2 && (((rs2 == rd_id_2_ex_ff) && reg_w_id_2_ex_ff) ||
                          ((rs2 == rd_ex_2_mem_ff) && reg_w_ex_2_mem_ff && mem_r_ex_2_mem_ff) ||
                          sb_hit2);
  assign stall_ctrl = haz1 || haz2;

  // Forwarding selects, EX/MEM over MEM/WB, suppressed while stalling
  always_comb begin
    fwd_rs1 = 2'b00;
    fwd_rs2 = 2'b00;
    if (!stall_ctrl) begin
      if (cand1 && (rs1 == rd_ex_2_mem_ff) && reg_w_ex_2_mem_ff && !mem_r_ex_2_mem_ff)
        fwd_rs1 = 2'b01;
      else if (cand1 && (rs1 == rd_mem_2_wb_ff) && reg_w_mem_2_wb_ff)
        fwd_rs1 = 2'b10;
      if (cand2 && (rs2 == rd_ex_2_mem_ff) && reg_w_ex_2_mem_ff && !mem_r_ex_2_mem_ff)
        fwd_rs2 = 2'b01;
      else if (cand2 && (rs2 == rd_mem_2_wb_ff) && reg_w_mem_2_wb_ff)
        fwd_rs2 = 2'b10;
    end
  end

  // Push/pop qualification; a push into a full FIFO is accepted only alongside a pop
  logic push, pop, full, push_ok, ovf;
  assign full    = (count_q == CNT_W'(LD_DEPTH));
  assign push    = ld_issue && (ld_issue_rd != '0);
  assign pop     = ld_resp_valid && (count_q != '0);
  assign push_ok = push && (!full || pop);
  assign ovf     = push && full && !pop;

  always_comb begin
    count_next = count_q;
    case ({push_ok, pop})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Scoreboard FIFO; on simultaneous push+pop at full, head==tail and the push wins the valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LD_DEPTH; i++) sb_rd[i] <= '0;
      sb_valid   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      sb_full    <= 1'b0;
      sb_ovf_err <= 1'b0;
    end else begin
      if (pop) begin
        sb_valid[head_q] <= 1'b0;
        head_q           <= ptr_inc(head_q);
      end
      if (push_ok) begin
        sb_valid[tail_q] <= 1'b1;
        sb_rd[tail_q]    <= ld_issue_rd;
        tail_q           <= ptr_inc(tail_q);
      end
      count_q <= count_next;
      sb_full <= (count_next == CNT_W'(LD_DEPTH));
      if (ovf) sb_ovf_err <= 1'b1;
    end
  end

  // Stall performance counter and watchdog streak
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      streak_q  <= '0;
      hang_err  <= 1'b0;
    end else begin
      if (stall_ctrl && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_CNT_WIDTH'(1);
      if (!stall_ctrl || flush) begin
        streak_q <= '0;
      end else if (streak_q != STRK_W'(STALL_TIMEOUT)) begin
        streak_q <= streak_q + STRK_W'(1);
        if (streak_q == STRK_W'(STALL_TIMEOUT - 1)) hang_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_ctrl_hazard_sb.sv
// Directed self-checking bench for ysyx_22050243_ctrl_hazard_sb (default parameters).
module tb_ysyx_22050243_ctrl_hazard_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_if_2_id_ff;
  logic        id_valid, flush;
  logic [4:0]  rd_id_2_ex_ff, rd_ex_2_mem_ff, rd_mem_2_wb_ff, ld_issue_rd;
  logic        reg_w_id_2_ex_ff, reg_w_ex_2_mem_ff, mem_r_ex_2_mem_ff, reg_w_mem_2_wb_ff;
  logic        ld_issue, ld_resp_valid;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic        stall_ctrl, sb_full, hang_err, sb_ovf_err;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_22050243_ctrl_hazard_sb dut (
    .clk               (clk),
    .rst               (rst),
    .inst_if_2_id_ff   (inst_if_2_id_ff),
    .id_valid          (id_valid),
    .flush             (flush),
    .rd_id_2_ex_ff     (rd_id_2_ex_ff),
    .reg_w_id_2_ex_ff  (reg_w_id_2_ex_ff),
    .rd_ex_2_mem_ff    (rd_ex_2_mem_ff),
    .reg_w_ex_2_mem_ff (reg_w_ex_2_mem_ff),
    .mem_r_ex_2_mem_ff (mem_r_ex_2_mem_ff),
    .rd_mem_2_wb_ff    (rd_mem_2_wb_ff),
    .reg_w_mem_2_wb_ff (reg_w_mem_2_wb_ff),
    .ld_issue          (ld_issue),
    .ld_issue_rd       (ld_issue_rd),
    .ld_resp_valid     (ld_resp_valid),
    .fwd_rs1           (fwd_rs1),
    .fwd_rs2           (fwd_rs2),
    .stall_ctrl        (stall_ctrl),
    .sb_full           (sb_full),
    .stall_cnt         (stall_cnt),
    .hang_err          (hang_err),
    .sb_ovf_err        (sb_ovf_err)
  );

  function automatic logic [31:0] jalr(input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic logic [31:0] branch(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction

  function automatic logic [31:0] alu(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd3, 7'b0110011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    inst_if_2_id_ff   = 32'h0000_0013;
    id_valid          = 1'b0;
    flush             = 1'b0;
    rd_id_2_ex_ff     = '0; reg_w_id_2_ex_ff  = 1'b0;
    rd_ex_2_mem_ff    = '0; reg_w_ex_2_mem_ff = 1'b0; mem_r_ex_2_mem_ff = 1'b0;
    rd_mem_2_wb_ff    = '0; reg_w_mem_2_wb_ff = 1'b0;
    ld_issue          = 1'b0; ld_issue_rd = '0; ld_resp_valid = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    n_tests++; if (fwd_rs1 !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_rs1 got %b exp 00", fwd_rs1); end
    n_tests++; if (fwd_rs2 !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_rs2 got %b exp 00", fwd_rs2); end
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_ctrl); end
    n_tests++; if (sb_full !== 1'b0) begin n_fail++; $display("FAIL reset_sb_full got %b exp 0", sb_full); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    n_tests++; if (hang_err !== 1'b0) begin n_fail++; $display("FAIL reset_hang got %b exp 0", hang_err); end
    n_tests++; if (sb_ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", sb_ovf_err); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_forward;
    do_reset();
    id_valid = 1'b1;
    inst_if_2_id_ff = branch(5'd5, 5'd6);
    rd_ex_2_mem_ff = 5'd6; reg_w_ex_2_mem_ff = 1'b1; mem_r_ex_2_mem_ff = 1'b0;
    rd_mem_2_wb_ff = 5'd5; reg_w_mem_2_wb_ff = 1'b1;
    #1;
    n_tests++; if (fwd_rs1 !== 2'b10) begin n_fail++; $display("FAIL fwd_basic_rs1 got %b exp 10", fwd_rs1); end
    n_tests++; if (fwd_rs2 !== 2'b01) begin n_fail++; $display("FAIL fwd_basic_rs2 got %b exp 01", fwd_rs2); end
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL fwd_basic_stall got %b exp 0", stall_ctrl); end
    // EX/MEM outranks MEM/WB for the same register
    rd_ex_2_mem_ff = 5'd5; rd_mem_2_wb_ff = 5'd5;
    #1;
    n_tests++; if (fwd_rs1 !== 2'b01) begin n_fail++; $display("FAIL fwd_prio_rs1 got %b exp 01", fwd_rs1); end
    n_tests++; if (fwd_rs2 !== 2'b00) begin n_fail++; $display("FAIL fwd_prio_rs2 got %b exp 00", fwd_rs2); end
    // load in EX/MEM stalls and masks the MEM/WB forward of rs2
    mem_r_ex_2_mem_ff = 1'b1; rd_mem_2_wb_ff = 5'd6;
    #1;
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL exmem_load_stall got %b exp 1", stall_ctrl); end
    n_tests++; if (fwd_rs2 !== 2'b00) begin n_fail++; $display("FAIL stall_masks_fwd got %b exp 00", fwd_rs2); end
    // ID/EX writer of rs2
    reg_w_ex_2_mem_ff = 1'b0; mem_r_ex_2_mem_ff = 1'b0;
    rd_id_2_ex_ff = 5'd6; reg_w_id_2_ex_ff = 1'b1;
    #1;
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL idex_stall got %b exp 1", stall_ctrl); end
    // no valid instruction: nothing used
    id_valid = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL invalid_stall got %b exp 0", stall_ctrl); end
    n_tests++; if (fwd_rs2 !== 2'b00) begin n_fail++; $display("FAIL invalid_fwd got %b exp 00", fwd_rs2); end
    // non-control opcode ignored
    id_valid = 1'b1; inst_if_2_id_ff = alu(5'd6, 5'd6);
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b exp 0", stall_ctrl); end
    // JALR does not use inst[24:20]
    inst_if_2_id_ff = jalr(5'd1, 12'h006);
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL jalr_rs2_field got %b exp 0", stall_ctrl); end
    n_tests++; if (fwd_rs1 !== 2'b00) begin n_fail++; $display("FAIL jalr_fwd got %b exp 00", fwd_rs1); end
  endtask

  task automatic test_x0;
    do_reset();
    id_valid = 1'b1;
    inst_if_2_id_ff = jalr(5'd0, 12'h000);
    rd_id_2_ex_ff = 5'd0; reg_w_id_2_ex_ff = 1'b1;
    rd_mem_2_wb_ff = 5'd0; reg_w_mem_2_wb_ff = 1'b1;
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b exp 0", stall_ctrl); end
    n_tests++; if (fwd_rs1 !== 2'b00) begin n_fail++; $display("FAIL x0_fwd got %b exp 00", fwd_rs1); end
    // pushing x0 must not create an entry
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    tick();
    ld_issue = 1'b0;
    reg_w_id_2_ex_ff = 1'b0; reg_w_mem_2_wb_ff = 1'b0;
    inst_if_2_id_ff = branch(5'd0, 5'd0);
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL x0_push_stall got %b exp 0", stall_ctrl); end
  endtask

  task automatic test_load_stall;
    do_reset();
    id_valid = 1'b1;
    inst_if_2_id_ff = jalr(5'd7, 12'h000);
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL ld_issue_cycle_stall got %b exp 0", stall_ctrl); end
    tick();
    ld_issue = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL ld_wait1_stall got %b exp 1", stall_ctrl); end
    tick();
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL ld_wait2_stall got %b exp 1", stall_ctrl); end
    tick();
    ld_resp_valid = 1'b1;
    #1;
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL ld_pop_cycle_stall got %b exp 1", stall_ctrl); end
    tick();
    ld_resp_valid = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL ld_release got %b exp 0", stall_ctrl); end
    n_tests++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL ld_stall_cnt got %0d exp 3", stall_cnt); end
    tick();
    n_tests++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL ld_stall_cnt_hold got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_sb_full;
    do_reset();
    ld_resp_valid = 1'b1;   // pop while empty, ignored
    tick();
    ld_resp_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      ld_issue = 1'b1; ld_issue_rd = 5'(i);
      tick();
      if (i == 3) begin
        n_tests++; if (sb_full !== 1'b0) begin n_fail++; $display("FAIL full_after3 got %b exp 0", sb_full); end
      end
      if (i == 4) begin
        n_tests++; if (sb_full !== 1'b1) begin n_fail++; $display("FAIL full_after4 got %b exp 1", sb_full); end
        n_tests++; if (sb_ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_after4 got %b exp 0", sb_ovf_err); end
      end
      if (i == 5) begin
        n_tests++; if (sb_ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_after5 got %b exp 1", sb_ovf_err); end
        n_tests++; if (sb_full !== 1'b1) begin n_fail++; $display("FAIL full_after5 got %b exp 1", sb_full); end
      end
    end
    ld_issue = 1'b0;

    // push+pop while full; x0 push is a no-op
    do_reset();
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      ld_issue_rd = 5'(i);
      tick();
    end
    n_tests++; if (sb_full !== 1'b1) begin n_fail++; $display("FAIL full_x0_skip got %b exp 1", sb_full); end
    ld_issue_rd = 5'd6; ld_resp_valid = 1'b1;
    tick();
    n_tests++; if (sb_full !== 1'b1) begin n_fail++; $display("FAIL pushpop_full got %b exp 1", sb_full); end
    n_tests++; if (sb_ovf_err !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf got %b exp 0", sb_ovf_err); end
    ld_issue_rd = 5'd7; ld_resp_valid = 1'b0;
    tick();
    n_tests++; if (sb_ovf_err !== 1'b1) begin n_fail++; $display("FAIL drop_ovf got %b exp 1", sb_ovf_err); end
    ld_issue = 1'b0;
    // contents now x2,x3,x4,x6; x7 dropped, x1 popped
    id_valid = 1'b1;
    inst_if_2_id_ff = branch(5'd7, 5'd1);
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL dropped_entry_stall got %b exp 0", stall_ctrl); end
    inst_if_2_id_ff = branch(5'd0, 5'd6);
    #1;
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL wrapped_entry_stall got %b exp 1", stall_ctrl); end
    inst_if_2_id_ff = branch(5'd2, 5'd0);
    ld_resp_valid = 1'b1;
    tick();
    ld_resp_valid = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL head_popped_stall got %b exp 0", stall_ctrl); end
    n_tests++; if (sb_full !== 1'b0) begin n_fail++; $display("FAIL full_after_pop got %b exp 0", sb_full); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    id_valid = 1'b1;
    inst_if_2_id_ff = branch(5'd9, 5'd0);
    ld_issue = 1'b1; ld_issue_rd = 5'd3;
    tick();
    ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL two_ld_stall got %b exp 1", stall_ctrl); end
    ld_resp_valid = 1'b1;
    tick();
    ld_resp_valid = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL after_pop1_stall got %b exp 1", stall_ctrl); end
    ld_resp_valid = 1'b1;
    tick();
    ld_resp_valid = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL after_pop2_stall got %b exp 0", stall_ctrl); end
    // reset during a scoreboard stall
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b1) begin n_fail++; $display("FAIL prerst_stall got %b exp 1", stall_ctrl); end
    rst = 1'b1;
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL async_rst_stall got %b exp 0", stall_ctrl); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst_cnt got %0d exp 0", stall_cnt); end
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL postrst_stall got %b exp 0", stall_ctrl); end
  endtask

  task automatic test_hang;
    do_reset();
    id_valid = 1'b1;
    inst_if_2_id_ff = jalr(5'd10, 12'h000);
    ld_issue = 1'b1; ld_issue_rd = 5'd10;
    tick();
    ld_issue = 1'b0;
    for (int k = 0; k < 63; k++) tick();
    n_tests++; if (hang_err !== 1'b0) begin n_fail++; $display("FAIL hang_at63 got %b exp 0", hang_err); end
    tick();
    n_tests++; if (hang_err !== 1'b1) begin n_fail++; $display("FAIL hang_at64 got %b exp 1", hang_err); end
    ld_resp_valid = 1'b1;
    tick();
    ld_resp_valid = 1'b0;
    #1;
    n_tests++; if (stall_ctrl !== 1'b0) begin n_fail++; $display("FAIL hang_release got %b exp 0", stall_ctrl); end
    n_tests++; if (stall_cnt !== 16'd65) begin n_fail++; $display("FAIL hang_stall_cnt got %0d exp 65", stall_cnt); end
    tick();
    n_tests++; if (hang_err !== 1'b1) begin n_fail++; $display("FAIL hang_sticky got %b exp 1", hang_err); end

    // flush restarts the streak
    do_reset();
    id_valid = 1'b1;
    inst_if_2_id_ff = jalr(5'd10, 12'h000);
    ld_issue = 1'b1; ld_issue_rd = 5'd10;
    tick();
    ld_issue = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    n_tests++; if (hang_err !== 1'b0) begin n_fail++; $display("FAIL flush_hang got %b exp 0", hang_err); end
    n_tests++; if (stall_cnt !== 16'd81) begin n_fail++; $display("FAIL flush_stall_cnt got %0d exp 81", stall_cnt); end
    for (int k = 0; k < 23; k++) tick();
    n_tests++; if (hang_err !== 1'b0) begin n_fail++; $display("FAIL flush_hang63 got %b exp 0", hang_err); end
    tick();
    n_tests++; if (hang_err !== 1'b1) begin n_fail++; $display("FAIL flush_hang64 got %b exp 1", hang_err); end
    ld_resp_valid = 1'b1;
    tick();
    ld_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_forward();
    test_x0();
    test_load_stall();
    test_sb_full();
    test_back_to_back();
    test_hang();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
